// File: rtl/univ_reg_cell_pkg.sv
// Shared definitions for the universal register cell: mode encodings used by
// the RTL and its bench.
package univ_reg_cell_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_INC  = 3'd6;
  localparam logic [2:0] MODE_DEC  = 3'd7;

endpackage

// File: rtl/univ_reg_slice.sv
// Per-bit next-state multiplexer: selects this bit's candidate value by mode.
module univ_reg_slice
  import univ_reg_cell_pkg::*;
(
  input  logic [2:0] mode,
  input  logic       cur,
  input  logic       ld,
  input  logic       shl,
  input  logic       shr,
  input  logic       rol,
  input  logic       ror,
  input  logic       inc,
  input  logic       dec,
  output logic       nxt
);

  always_comb begin
    nxt = cur;
    case (mode)
      MODE_HOLD: nxt = cur;
      MODE_LOAD: nxt = ld;
      MODE_SHL:  nxt = shl;
      MODE_SHR:  nxt = shr;
      MODE_ROL:  nxt = rol;
      MODE_ROR:  nxt = ror;
      MODE_INC:  nxt = inc;
      MODE_DEC:  nxt = dec;
      default:   nxt = cur;
    endcase
  end

endmodule

// File: rtl/univ_reg_cell.sv
// Universal register cell: hold/load/shift/rotate/count with a registered
// terminal-count pulse on counter wrap.
module univ_reg_cell
  import univ_reg_cell_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] notq,
  output logic             sout_l,
  output logic             sout_r,
  output logic             tc
);

  logic [WIDTH-1:0] shl_v, shr_v, rol_v, ror_v;
  logic [WIDTH-1:0] inc_v, dec_v, q_nxt;
  logic             carry, borrow, wrap;

  assign shl_v = {q[WIDTH-2:0], sin_l};
  assign shr_v = {sin_r, q[WIDTH-1:1]};
  assign rol_v = {q[WIDTH-2:0], q[WIDTH-1]};
  assign ror_v = {q[0], q[WIDTH-1:1]};

  // Carry/borrow out of the MSB only feed tc; q keeps the low WIDTH bits.
  assign {carry, inc_v}  = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
  assign {borrow, dec_v} = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};

  assign wrap = ((mode == MODE_INC) && carry) || ((mode == MODE_DEC) && borrow);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    univ_reg_slice u_slice (
      .mode (mode),
      .cur  (q[i]),
      .ld   (d[i]),
      .shl  (shl_v[i]),
      .shr  (shr_v[i]),
      .rol  (rol_v[i]),
      .ror  (ror_v[i]),
      .inc  (inc_v[i]),
      .dec  (dec_v[i]),
      .nxt  (q_nxt[i])
    );
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q  <= RESET_VALUE[WIDTH-1:0];
      tc <= 1'b0;
    end else if (en) begin
      q  <= q_nxt;
      tc <= wrap;
    end
  end

  assign notq   = ~q;
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_univ_reg_cell.sv
// Scoreboard bench for univ_reg_cell: default 8-bit cell, 8-bit cell with
// RESET_VALUE=0x3C, and a 2-bit cell for rotate/wrap corners.
module tb_univ_reg_cell;
  import univ_reg_cell_pkg::*;

  typedef struct {
    int         id;
    logic [7:0] q;
    logic       tc;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       ra = 1'b0, rb = 1'b0, rc = 1'b0;
  logic       ena = 1'b0, enb = 1'b0, enc = 1'b0;
  logic [2:0] mode = MODE_HOLD;
  logic [7:0] dd = '0;
  logic       sl = 1'b0, sr = 1'b0;

  logic [7:0] qa, nqa, qb, nqb;
  logic [1:0] qc, nqc;
  logic       sla, sra, tca, slb, srb, tcb, slc, src, tcc;

  exp_t sbq[$];
  event sample_ev;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  univ_reg_cell u_dut_a (
    .clk(clk), .r(ra), .en(ena), .mode(mode), .d(dd), .sin_l(sl), .sin_r(sr),
    .q(qa), .notq(nqa), .sout_l(sla), .sout_r(sra), .tc(tca)
  );

  univ_reg_cell #(.WIDTH(8), .RESET_VALUE(32'h3C)) u_dut_b (
    .clk(clk), .r(rb), .en(enb), .mode(mode), .d(dd), .sin_l(sl), .sin_r(sr),
    .q(qb), .notq(nqb), .sout_l(slb), .sout_r(srb), .tc(tcb)
  );

  univ_reg_cell #(.WIDTH(2)) u_dut_c (
    .clk(clk), .r(rc), .en(enc), .mode(mode), .d(dd[1:0]), .sin_l(sl), .sin_r(sr),
    .q(qc), .notq(nqc), .sout_l(slc), .sout_r(src), .tc(tcc)
  );

  task automatic push_exp(input int id, input logic [7:0] q, input logic tc, input string name);
    exp_t e;
    e.id = id; e.q = q; e.tc = tc; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic ea, input logic eb, input logic ec, input logic [2:0] m,
                       input logic [7:0] dv, input logic l, input logic rr);
    @(negedge clk);
    ena = ea; enb = eb; enc = ec; mode = m; dd = dv; sl = l; sr = rr;
  endtask

  task automatic async_rst(input int id, input logic [7:0] q, input string name);
    @(negedge clk);
    #2;
    case (id)
      0: ra = 1'b1;
      1: rb = 1'b1;
      default: rc = 1'b1;
    endcase
    push_exp(id, q, 1'b0, name);
    ->sample_ev;
  endtask

  task automatic check(input exp_t e);
    logic [7:0] aq, anq, enq;
    logic       asl, asr, atc, esl, esr;
    case (e.id)
      0: begin aq = qa; anq = nqa; asl = sla; asr = sra; atc = tca;
               enq = ~e.q; esl = e.q[7]; esr = e.q[0]; end
      1: begin aq = qb; anq = nqb; asl = slb; asr = srb; atc = tcb;
               enq = ~e.q; esl = e.q[7]; esr = e.q[0]; end
      default: begin aq = {6'b0, qc}; anq = {6'b0, nqc}; asl = slc; asr = src; atc = tcc;
               enq = {6'b0, ~e.q[1:0]}; esl = e.q[1]; esr = e.q[0]; end
    endcase
    compared++;
    if (aq !== e.q || anq !== enq || asl !== esl || asr !== esr || atc !== e.tc) begin
      mismatched++;
      $display("FAIL %s: dut%0d got q=%h notq=%h sout_l=%b sout_r=%b tc=%b, want q=%h notq=%h sout_l=%b sout_r=%b tc=%b",
               e.name, e.id, aq, anq, asl, asr, atc, e.q, enq, esl, esr, e.tc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or sample_ev);
      #1;
      while (sbq.size() > 0) check(sbq.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    ra = 1'b1; rb = 1'b1; rc = 1'b1;
    #2;
    push_exp(0, 8'h00, 1'b0, "reset_a");
    push_exp(1, 8'h3C, 1'b0, "reset_b");
    push_exp(2, 8'h00, 1'b0, "reset_c");
    ->sample_ev;
    @(negedge clk);
    ra = 1'b0; rb = 1'b0; rc = 1'b0;

    // Load and hold
    drive(1, 0, 0, MODE_LOAD, 8'hA5, 0, 0); push_exp(0, 8'hA5, 0, "load_a5");
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, MODE_HOLD, 8'h00, 0, 0); push_exp(0, 8'hA5, 0, "hold_a5");
    end
    // Shifts
    drive(1, 0, 0, MODE_LOAD, 8'h81, 0, 0); push_exp(0, 8'h81, 0, "load_81");
    drive(1, 0, 0, MODE_SHL,  8'h00, 1, 0); push_exp(0, 8'h03, 0, "shl_sin1");
    drive(1, 0, 0, MODE_SHR,  8'h00, 0, 0); push_exp(0, 8'h01, 0, "shr_sin0");
    drive(1, 0, 0, MODE_SHR,  8'h00, 0, 1); push_exp(0, 8'h80, 0, "shr_sin1");
    // Rotates
    drive(1, 0, 0, MODE_LOAD, 8'h81, 0, 0); push_exp(0, 8'h81, 0, "load_81b");
    drive(1, 0, 0, MODE_ROR,  8'h00, 1, 1); push_exp(0, 8'hC0, 0, "ror");
    drive(1, 0, 0, MODE_ROL,  8'h00, 0, 0); push_exp(0, 8'h81, 0, "rol");
    // Count wrap up and down
    drive(1, 0, 0, MODE_LOAD, 8'hFE, 0, 0); push_exp(0, 8'hFE, 0, "load_fe");
    drive(1, 0, 0, MODE_INC,  8'h00, 0, 0); push_exp(0, 8'hFF, 0, "inc_ff");
    drive(1, 0, 0, MODE_INC,  8'h00, 0, 0); push_exp(0, 8'h00, 1, "inc_wrap");
    drive(1, 0, 0, MODE_INC,  8'h00, 0, 0); push_exp(0, 8'h01, 0, "inc_after");
    drive(1, 0, 0, MODE_LOAD, 8'h00, 0, 0); push_exp(0, 8'h00, 0, "load_00");
    drive(1, 0, 0, MODE_DEC,  8'h00, 0, 0); push_exp(0, 8'hFF, 1, "dec_wrap");
    drive(0, 0, 0, MODE_DEC,  8'h00, 0, 0); push_exp(0, 8'hFF, 1, "tc_hold_en0");
    drive(1, 0, 0, MODE_HOLD, 8'h00, 0, 0); push_exp(0, 8'hFF, 0, "tc_clear");
    // Enable gating while counting
    drive(1, 0, 0, MODE_LOAD, 8'h00, 0, 0); push_exp(0, 8'h00, 0, "load_00b");
    drive(1, 0, 0, MODE_INC,  8'h00, 0, 0); push_exp(0, 8'h01, 0, "en_step1");
    drive(0, 0, 0, MODE_INC,  8'h00, 0, 0); push_exp(0, 8'h01, 0, "en_step2");
    drive(1, 0, 0, MODE_INC,  8'h00, 0, 0); push_exp(0, 8'h02, 0, "en_step3");
    drive(0, 0, 0, MODE_INC,  8'h00, 0, 0); push_exp(0, 8'h02, 0, "en_step4");

    // 2-bit cell: rotates swap, wraps
    drive(0, 0, 1, MODE_LOAD, 8'h01, 0, 0); push_exp(2, 8'h01, 0, "w2_load");
    drive(0, 0, 1, MODE_ROL,  8'h00, 0, 0); push_exp(2, 8'h02, 0, "w2_rol");
    drive(0, 0, 1, MODE_ROR,  8'h00, 0, 0); push_exp(2, 8'h01, 0, "w2_ror");
    drive(0, 0, 1, MODE_ROR,  8'h00, 0, 0); push_exp(2, 8'h02, 0, "w2_ror2");
    drive(0, 0, 1, MODE_LOAD, 8'h03, 0, 0); push_exp(2, 8'h03, 0, "w2_load3");
    drive(0, 0, 1, MODE_INC,  8'h00, 0, 0); push_exp(2, 8'h00, 1, "w2_inc_wrap");
    drive(0, 0, 1, MODE_DEC,  8'h00, 0, 0); push_exp(2, 8'h03, 1, "w2_dec_wrap");

    // Async reset mid-count with RESET_VALUE=0x3C
    drive(0, 1, 0, MODE_INC, 8'h00, 0, 0); push_exp(1, 8'h3D, 0, "b_inc1");
    drive(0, 1, 0, MODE_INC, 8'h00, 0, 0); push_exp(1, 8'h3E, 0, "b_inc2");
    async_rst(1, 8'h3C, "b_async_rst");
    drive(0, 1, 0, MODE_INC, 8'h00, 0, 0); push_exp(1, 8'h3C, 0, "b_rst_edge1");
    drive(0, 1, 0, MODE_LOAD, 8'hFF, 0, 0); push_exp(1, 8'h3C, 0, "b_rst_edge2");
    drive(0, 1, 0, MODE_INC, 8'h00, 0, 0); rb = 1'b0; push_exp(1, 8'h3D, 0, "b_release");

    // Async reset clears a pending tc
    drive(1, 0, 0, MODE_LOAD, 8'h00, 0, 0); push_exp(0, 8'h00, 0, "load_00c");
    drive(1, 0, 0, MODE_DEC,  8'h00, 0, 0); push_exp(0, 8'hFF, 1, "dec_wrap2");
    async_rst(0, 8'h00, "a_async_rst_tc");

    @(posedge clk);
    #3;
    if (sbq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations unchecked, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
